// File: rtl/hacd_csr_responder.sv
// HACD configuration CSR responder (register-interface slave end).
// Holds control/status/interrupt/scratch CSRs and an atomically committed
// 64-bit base address; drives a registered interrupt.
// Optional build macro: HACD_CSR_ERR_EN (unmapped-access error reporting
// plus sticky ERR bit in IRQ_STATUS[31]).
module hacd_csr_responder #(
  parameter int unsigned NUM_EVT    = 4,
  parameter int unsigned ACCESS_LAT = 1,
  parameter int unsigned ADDR_DEC_W = 8
) (
  input  logic               cfg_clk_i,
  input  logic               cfg_rst_i,
  input  logic               req_valid_i,
  input  logic               req_write_i,
  input  logic [31:0]        req_addr_i,
  input  logic [31:0]        req_wdata_i,
  input  logic [3:0]         req_wstrb_i,
  output logic               resp_ready_o,
  output logic [31:0]        resp_rdata_o,
  output logic               resp_error_o,
  input  logic [31:0]        hw_status_i,
  input  logic [NUM_EVT-1:0] hw_evt_i,
  output logic [31:0]        ctrl_o,
  output logic [63:0]        base_addr_o,
  output logic               irq_o
);

  localparam logic [31:0] VERSION  = 32'h4841_0001;
  // Shift by 32 wraps to 0, so the subtraction yields all-ones at full width.
  localparam logic [31:0] DEC_MASK = (32'd1 << ADDR_DEC_W) - 32'd1;
  localparam logic [31:0] EVT_MASK = (32'd1 << NUM_EVT) - 32'd1;
  localparam logic        LAT_EN   = (ACCESS_LAT != 0);
  localparam logic [2:0]  LAT_INIT = (ACCESS_LAT == 0) ? 3'd0 : 3'(ACCESS_LAT - 1);

`ifdef HACD_CSR_ERR_EN
  localparam logic [31:0] STAT_MASK = EVT_MASK | 32'h8000_0000;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] STAT_MASK = EVT_MASK;
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;
`endif

  typedef enum logic {
    S_IDLE,
    S_RECOVER
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        ready_q;

  logic [31:0] ctrl_q;
  logic [31:0] irq_status_q;
  logic [31:0] irq_en_q;
  logic [31:0] scratch_q;
  logic [31:0] lo_shadow_q;
  logic [31:0] hi_snap_q;
  logic [63:0] base_q;
  logic        irq_q;

  logic        accept;
  logic [31:0] dec_addr;
  logic [2:0]  word;
  logic        unmapped;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] bmask;
  logic [31:0] rd_mux;
  logic [31:0] irq_status_nxt;
  logic        unused_bits;

  assign accept      = req_valid_i & resp_ready_o;
  assign dec_addr    = req_addr_i & DEC_MASK;
  assign word        = dec_addr[4:2];
  assign unmapped    = |dec_addr[31:5];
  assign wr_en       = accept & req_write_i & ~unmapped;
  assign rd_en       = accept & ~req_write_i & ~unmapped;
  assign bmask       = {{8{req_wstrb_i[3]}}, {8{req_wstrb_i[2]}},
                        {8{req_wstrb_i[1]}}, {8{req_wstrb_i[0]}}};
  assign unused_bits = &{1'b0, dec_addr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Read data mux over the mapped word offsets.
  always_comb begin
    rd_mux = '0;
    case (word)
      3'd0: rd_mux = ctrl_q;
      3'd1: rd_mux = hw_status_i;
      3'd2: rd_mux = irq_status_q;
      3'd3: rd_mux = irq_en_q;
      3'd4: rd_mux = scratch_q;
      3'd5: rd_mux = base_q[31:0];
      3'd6: rd_mux = hi_snap_q;
      3'd7: rd_mux = VERSION;
      default: rd_mux = '0;
    endcase
  end

  // Response data/error are combinational in the accept cycle only.
  always_comb begin
    resp_rdata_o = '0;
    resp_error_o = 1'b0;
    if (accept && !req_write_i)
      resp_rdata_o = unmapped ? ERR_RDATA : rd_mux;
`ifdef HACD_CSR_ERR_EN
    resp_error_o = accept & unmapped;
`endif
  end

  // Interrupt status next state: new events win over a same-cycle W1C.
  always_comb begin
    logic [31:0] clr;
    logic [31:0] set;
    clr = '0;
    set = 32'(hw_evt_i);
    if (wr_en && word == 3'd2)
      clr = req_wdata_i & bmask;
`ifdef HACD_CSR_ERR_EN
    set[31] = accept & unmapped;
`endif
    irq_status_nxt = ((irq_status_q & ~clr) | set) & STAT_MASK;
  end

  // Ready FSM: hold ready low for ACCESS_LAT cycles after each accept.
  always_ff @(posedge cfg_clk_i) begin
    if (cfg_rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && LAT_EN) begin
            state   <= S_RECOVER;
            cnt     <= LAT_INIT;
            ready_q <= 1'b0;
          end
        end
        S_RECOVER: begin
          if (cnt == '0) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // CSR storage, base-address commit, read snapshot and interrupt register.
  always_ff @(posedge cfg_clk_i) begin
    if (cfg_rst_i) begin
      ctrl_q       <= '0;
      irq_status_q <= '0;
      irq_en_q     <= '0;
      scratch_q    <= '0;
      lo_shadow_q  <= '0;
      hi_snap_q    <= '0;
      base_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_en) begin
        case (word)
          3'd0: ctrl_q      <= merge(ctrl_q, req_wdata_i, bmask);
          3'd3: irq_en_q    <= merge(irq_en_q, req_wdata_i, bmask);
          3'd4: scratch_q   <= merge(scratch_q, req_wdata_i, bmask);
          3'd5: lo_shadow_q <= merge(lo_shadow_q, req_wdata_i, bmask);
          3'd6: base_q      <= {merge(base_q[63:32], req_wdata_i, bmask), lo_shadow_q};
          default: ;
        endcase
      end
      if (rd_en && word == 3'd5)
        hi_snap_q <= base_q[63:32];
      irq_status_q <= irq_status_nxt;
      irq_q        <= |(irq_status_q & irq_en_q);
    end
  end

  assign resp_ready_o = ready_q;
  assign ctrl_o       = ctrl_q;
  assign base_addr_o  = base_q;
  assign irq_o        = irq_q;

endmodule
